// File: rtl/core_alu_pkg.sv
// Shared op encoding, op-class helpers and the multiply/divide FSM state type
// for the pipelined execute-stage ALU.
package core_alu_pkg;

   localparam int OP_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SRL    = 5'd3,
      OP_SRA    = 5'd4,
      OP_SLT    = 5'd5,
      OP_SLTU   = 5'd6,
      OP_XOR    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_BEQ    = 5'd10,
      OP_BNE    = 5'd11,
      OP_BLT    = 5'd12,
      OP_BGE    = 5'd13,
      OP_BLTU   = 5'd14,
      OP_BGEU   = 5'd15,
      OP_LOAD   = 5'd16,
      OP_STORE  = 5'd17,
      OP_MUL    = 5'd18,
      OP_MULH   = 5'd19,
      OP_MULHSU = 5'd20,
      OP_MULHU  = 5'd21,
      OP_DIV    = 5'd22,
      OP_DIVU   = 5'd23,
      OP_REM    = 5'd24,
      OP_REMU   = 5'd25
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
   endfunction

   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_mul(input logic [OP_W-1:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

endpackage

// File: rtl/core_alu_muldiv.sv
// Iterative RV-M multiply/divide: one bit per cycle on magnitudes, sign fixed
// at the end. Instantiated by core_alu_pipe only when CORE_ALU_MULDIV_EN is defined.
module core_alu_muldiv
   import core_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            ack,
   output logic            idle,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN);

   md_state_e         state, state_d;
   logic [CNT_W-1:0]  cnt;
   logic [OP_W-1:0]   op_q;
   logic [2*XLEN-1:0] acc, step, prod;
   logic [XLEN-1:0]   dv, ma, mb, quo, rem;
   logic [XLEN:0]     sum, trial, diff;
   logic              sa, sb, ge, neg_q, neg_r, dz;

   assign idle = (state == MD_IDLE);
   assign done = (state == MD_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         MD_IDLE: if (start) state_d = MD_RUN;
         MD_RUN:  if (cnt == CNT_W'(XLEN-1)) state_d = MD_DONE;
         MD_DONE: if (ack) state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      sa = 1'b0;
      sb = 1'b0;
      case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            sa = a[XLEN-1];
            sb = b[XLEN-1];
         end
         OP_MULHSU: sa = a[XLEN-1];
         default: ;
      endcase
      ma = sa ? -a : a;
      mb = sb ? -b : b;
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dv} : {(XLEN+1){1'b0}});
      trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff  = trial - {1'b0, dv};
      ge    = (trial >= {1'b0, dv});
      if (is_mul(op_q)) step = {sum, acc[XLEN-1:1]};
      else              step = {(ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc[XLEN-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         op_q  <= '0;
         acc   <= '0;
         dv    <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
      end else if (state == MD_IDLE && start) begin
         cnt   <= '0;
         op_q  <= op;
         acc   <= {{XLEN{1'b0}}, ma};
         dv    <= mb;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         dz    <= (b == '0);
      end else if (state == MD_RUN) begin
         cnt <= cnt + 1'b1;
         acc <= step;
      end
   end

   // A zero divisor leaves the dividend in the remainder half, which is the required REM result
   always_comb begin
      prod   = neg_q ? -acc : acc;
      quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      result = '0;
      case (op_q)
         OP_MUL:                       result = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result = dz ? '1 : quo;
         OP_REM, OP_REMU:              result = rem;
         default: ;
      endcase
   end

endmodule

// File: rtl/core_alu_pipe.sv
// Two-stage valid/ready execute ALU with branch compare and in-order tags.
// Define CORE_ALU_MULDIV_EN to add the iterative M-extension unit on the same output.
module core_alu_pipe
   import core_alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_use_imm,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic             out_br_taken,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int STAGES = 2;
   localparam int SH_W   = $clog2(XLEN);

   logic [STAGES:1]  vld_pipe;
   logic [OP_W-1:0]  s1_op;
   logic [XLEN-1:0]  s1_a, s1_b, alu_res, md_res;
   logic [TAG_W-1:0] s1_tag, md_tag;
   logic [SH_W-1:0]  shamt;
   logic             alu_br, eq, lt_s, lt_u;
   logic             s2_load, s1_is_md, s1_move, s1_load, md_start, md_idle, md_done, md_take;

   assign s2_load  = !vld_pipe[2] | out_ready;
   assign s1_move  = vld_pipe[1] & !s1_is_md & s2_load;
   assign md_start = s1_is_md & md_idle;
   assign md_take  = md_done & s2_load;
   // A muldiv op in S1 already blocks intake so nothing can overtake it
   assign in_ready = (!vld_pipe[1] | s1_move) & md_idle & !s1_is_md;
   assign s1_load  = in_valid & in_ready;
   assign out_valid = vld_pipe[2];
   assign busy      = (|vld_pipe) | !md_idle;

`ifdef CORE_ALU_MULDIV_EN
   assign s1_is_md = vld_pipe[1] & is_muldiv(s1_op);

   always_ff @(posedge clk) begin
      if (rst)           md_tag <= '0;
      else if (md_start) md_tag <= s1_tag;
   end

   core_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .ack    (s2_load),
      .idle   (md_idle),
      .done   (md_done),
      .result (md_res)
   );
`else
   assign s1_is_md = 1'b0;
   assign md_idle  = 1'b1;
   assign md_done  = 1'b0;
   assign md_res   = '0;
   assign md_tag   = '0;
`endif

   assign shamt = s1_b[SH_W-1:0];
   assign eq    = (s1_a == s1_b);
   assign lt_s  = ($signed(s1_a) < $signed(s1_b));
   assign lt_u  = (s1_a < s1_b);

   always_comb begin
      alu_res = '0;
      alu_br  = 1'b0;
      case (s1_op)
         OP_ADD, OP_LOAD, OP_STORE: alu_res = s1_a + s1_b;
         OP_SUB:  alu_res = s1_a - s1_b;
         OP_SLL:  alu_res = s1_a << shamt;
         OP_SRL:  alu_res = s1_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(s1_a) >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         OP_XOR:  alu_res = s1_a ^ s1_b;
         OP_OR:   alu_res = s1_a | s1_b;
         OP_AND:  alu_res = s1_a & s1_b;
         OP_BEQ:  alu_br  = eq;
         OP_BNE:  alu_br  = !eq;
         OP_BLT:  alu_br  = lt_s;
         OP_BGE:  alu_br  = !lt_s;
         OP_BLTU: alu_br  = lt_u;
         OP_BGEU: alu_br  = !lt_u;
         default: ;
      endcase
      if (!is_branch(s1_op)) alu_br = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe     <= '0;
         s1_op        <= '0;
         s1_a         <= '0;
         s1_b         <= '0;
         s1_tag       <= '0;
         out_result   <= '0;
         out_br_taken <= 1'b0;
         out_tag      <= '0;
      end else begin
         if (s1_load) begin
            s1_op  <= in_op;
            s1_a   <= in_rs1;
            s1_b   <= in_use_imm ? in_imm : in_rs2;
            s1_tag <= in_tag;
         end
         if (s1_load)                  vld_pipe[1] <= 1'b1;
         else if (s1_move | md_start)  vld_pipe[1] <= 1'b0;
         if (s2_load) vld_pipe[2] <= s1_move | md_take;
         if (s1_move) begin
            out_result   <= alu_res;
            out_br_taken <= alu_br;
            out_tag      <= s1_tag;
         end else if (md_take) begin
            out_result   <= md_res;
            out_br_taken <= 1'b0;
            out_tag      <= md_tag;
         end
      end
   end

endmodule
